// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - memory, redirect and decoder signals of the fetch unit
interface instruction_fetch_unit_if;
  logic        mem_request;
  logic [31:0] mem_address;
  logic        mem_accept;
  logic        mem_read_valid;
  logic [31:0] mem_read_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        misaligned_fetch;

  modport master (
    output mem_request, mem_address, instruction_valid, instruction, instruction_pc,
           misaligned_fetch,
    input  mem_accept, mem_read_valid, mem_read_data, redirect, redirect_target,
           instruction_ready
  );

  modport slave (
    input  mem_request, mem_address, instruction_valid, instruction, instruction_pc,
           misaligned_fetch,
    output mem_accept, mem_read_valid, mem_read_data, redirect, redirect_target,
           instruction_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner with in-order fetch buffer feeding the decoder
// Define IFU_PERF_COUNTERS_EN to add o_fetch_count / o_discarded_count.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BUFFER_DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
`ifdef IFU_PERF_COUNTERS_EN
  output logic [31:0]              o_fetch_count,
  output logic [31:0]              o_discarded_count,
`endif
  instruction_fetch_unit_if.master ifu
);
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(BUFFER_DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding, r_discard, r_count;
  logic [PW-1:0] r_head, r_tail, r_aq_head;
  logic [31:0]   r_buf_word [BUFFER_DEPTH];
  logic [31:0]   r_buf_pc   [BUFFER_DEPTH];
  logic [31:0]   r_aq_pc    [BUFFER_DEPTH];
  logic          r_misaligned;

  logic          w_accept, w_rsp, w_push, w_pop, w_valid, w_misaligned_target;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_outstanding_next, w_discard_next;
  logic [PW-1:0] w_aq_tail;

  // Outstanding survives reset so responses to pre-reset requests can still be drained.
  assign w_inflight          = {1'b0, r_outstanding} + {1'b0, r_count};
  assign ifu.mem_request     = !i_rst && (r_state == S_RUN) && (w_inflight < LP_DEPTH);
  assign ifu.mem_address     = r_fetch_pc;
  assign w_accept            = ifu.mem_request && ifu.mem_accept;
  assign w_rsp               = ifu.mem_read_valid && (r_outstanding != '0);
  assign w_outstanding_next  = r_outstanding + CW'(w_accept) - CW'(w_rsp);
  assign w_valid             = (r_count != '0);
  assign w_push              = !i_rst && (r_state == S_RUN) && w_rsp && !ifu.redirect;
  assign w_pop               = !i_rst && w_valid && ifu.instruction_ready && !ifu.redirect;
  assign w_aq_tail           = r_aq_head + PW'(r_outstanding);
  assign w_misaligned_target = (ifu.redirect_target[1:0] != 2'b00);

  assign ifu.instruction_valid = w_valid;
  assign ifu.instruction       = w_valid ? r_buf_word[r_head] : '0;
  assign ifu.instruction_pc    = w_valid ? r_buf_pc[r_head] : '0;
  assign ifu.misaligned_fetch  = r_misaligned;

  always_comb begin
    w_state_next   = r_state;
    w_discard_next = r_discard;
    if (ifu.redirect) begin
      w_discard_next = w_outstanding_next;
      if (w_misaligned_target)             w_state_next = S_HALT;
      else if (w_outstanding_next != '0)   w_state_next = S_DRAIN;
      else                                 w_state_next = S_RUN;
    end else if ((r_state != S_RUN) && w_rsp && (r_discard != '0)) begin
      w_discard_next = r_discard - CW'(1);
      if ((r_state == S_DRAIN) && (r_discard == CW'(1))) w_state_next = S_RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    r_outstanding <= w_outstanding_next;
    if (w_rsp)    r_aq_head <= r_aq_head + PW'(1);
    if (w_accept) r_aq_pc[w_aq_tail] <= r_fetch_pc;
    if (w_push) begin
      r_buf_word[r_tail] <= ifu.mem_read_data;
      r_buf_pc[r_tail]   <= r_aq_pc[r_aq_head];
    end
    if (i_rst) begin
      r_state      <= (w_outstanding_next != '0) ? S_DRAIN : S_RUN;
      r_discard    <= w_outstanding_next;
      r_fetch_pc   <= RESET_VECTOR;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_discard <= w_discard_next;
      if (ifu.redirect) begin
        r_fetch_pc <= ifu.redirect_target;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
        if (w_misaligned_target) r_misaligned <= 1'b1;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)   r_tail <= r_tail + PW'(1);
        if (w_pop)    r_head <= r_head + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] r_fetch_count, r_discarded_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_count     <= '0;
      r_discarded_count <= '0;
    end else begin
      if (w_pop)            r_fetch_count     <= r_fetch_count + 32'd1;
      if (w_rsp && !w_push) r_discarded_count <= r_discarded_count + 32'd1;
    end
  end

  assign o_fetch_count     = r_fetch_count;
  assign o_discarded_count = r_discarded_count;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - bench for instruction_fetch_unit with in-order memory model
module tb_instruction_fetch_unit;
  localparam int          D  = 2;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_fetch_unit_if bus();
`ifdef IFU_PERF_COUNTERS_EN
  logic [31:0] fetch_count, discarded_count;
`endif

  instruction_fetch_unit #(.RESET_VECTOR(RV), .BUFFER_DEPTH(D)) dut (
    .i_clk(clk),
    .i_rst(rst),
`ifdef IFU_PERF_COUNTERS_EN
    .o_fetch_count(fetch_count),
    .o_discarded_count(discarded_count),
`endif
    .ifu(bus)
  );

  typedef struct {
    logic [31:0] acc, rv, rd, rdy, redir, tgt, e_req, e_addr, e_iv, e_ipc;
  } vec_t;
  vec_t vt [11];

  int compared = 0, mismatched = 0;
  int cyc = 0, last_due = -1, n_pop = 0, pop_since_rst = 0, p0;
  int acc_pct = 0, rdy_pct = 0, lat_min = 1, lat_max = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic        do_redirect = 1'b0;
  logic [31:0] redirect_to = '0;
  logic [31:0] exp_pc = RV, exp_req = RV, prev_pc = '0, prev_instr = '0;
  logic        exp_mis = 1'b0, halted = 1'b0, prev_hold = 1'b0;
  logic        last_rv = 1'b0, last_acc = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of environment: memory responder, decoder, and the architectural reference.
  task automatic tick();
    logic rsp_now, pop;
    int   due;
    rsp_now = 1'b0;
    bus.mem_accept        = ($urandom_range(0, 99) < acc_pct);
    bus.instruction_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.mem_read_valid    = 1'b0;
    bus.mem_read_data     = '0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.mem_read_valid = 1'b1;
      bus.mem_read_data  = word(pend_addr[0]);
      rsp_now = 1'b1;
    end
    bus.redirect        = do_redirect;
    bus.redirect_target = redirect_to;
    @(negedge clk);
    last_rv  = bus.mem_read_valid;
    last_acc = bus.mem_request && bus.mem_accept;
    if (cyc > 0) check("misaligned", bus.misaligned_fetch, exp_mis);
    if (halted) begin
      check("halt_no_req", bus.mem_request, 0);
      check("halt_no_valid", bus.instruction_valid, 0);
    end
    if (rsp_now) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (last_acc) begin
      check("fetch_addr", bus.mem_address, exp_req);
      exp_req = exp_req + 32'd4;
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(bus.mem_address);
      pend_due.push_back(due);
    end
    check("cap", pend_addr.size() <= D, 1);
    if (prev_hold && !rst) begin
      check("hold_valid", bus.instruction_valid, 1);
      check("hold_pc", bus.instruction_pc, prev_pc);
      check("hold_word", bus.instruction, prev_instr);
    end
    pop = bus.instruction_valid && bus.instruction_ready && !bus.redirect && !rst;
    if (pop) begin
      check("pop_pc", bus.instruction_pc, exp_pc);
      check("pop_word", bus.instruction, word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_pop++;
      pop_since_rst++;
    end
    prev_hold  = bus.instruction_valid && !bus.instruction_ready && !bus.redirect && !rst;
    prev_pc    = bus.instruction_pc;
    prev_instr = bus.instruction;
    if (rst) begin
      exp_pc = RV; exp_req = RV; halted = 1'b0; exp_mis = 1'b0; pop_since_rst = 0;
    end else if (bus.redirect) begin
      if (bus.redirect_target[1:0] != 2'b00) begin
        halted = 1'b1; exp_mis = 1'b1;
      end else begin
        halted = 1'b0; exp_pc = bus.redirect_target; exp_req = bus.redirect_target;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect_once(input logic [31:0] t);
    do_redirect = 1'b1;
    redirect_to = t;
    tick();
    do_redirect = 1'b0;
  endtask

  initial begin
    //        acc rv rd     rdy red tgt    | req addr    iv ipc
    vt[0]  = '{1, 0, 0,     1,  0,  0,       1, 'h0,   0, 'h0};
    vt[1]  = '{1, 1, 'h0,   1,  0,  0,       1, 'h4,   0, 'h0};
    vt[2]  = '{1, 1, 'h4,   1,  0,  0,       0, 'h8,   1, 'h0};
    vt[3]  = '{1, 0, 0,     1,  0,  0,       1, 'h8,   1, 'h4};
    vt[4]  = '{1, 1, 'h8,   1,  0,  0,       1, 'hC,   0, 'h0};
    vt[5]  = '{1, 1, 'hC,   1,  1,  'h100,   0, 'h10,  1, 'h8};
    vt[6]  = '{1, 0, 0,     1,  0,  0,       1, 'h100, 0, 'h0};
    vt[7]  = '{0, 1, 'h100, 1,  0,  0,       1, 'h104, 0, 'h0};
    vt[8]  = '{0, 0, 0,     0,  0,  0,       1, 'h104, 1, 'h100};
    vt[9]  = '{0, 0, 0,     1,  0,  0,       1, 'h104, 1, 'h100};
    vt[10] = '{0, 0, 0,     1,  0,  0,       1, 'h104, 0, 'h0};

    rst = 1'b1;
    tick();
    tick();
    check("rst_req", bus.mem_request, 0);
    check("rst_addr", bus.mem_address, RV);
    check("rst_valid", bus.instruction_valid, 0);
    check("rst_instr", bus.instruction, 0);
    check("rst_pc", bus.instruction_pc, 0);
    check("rst_mis", bus.misaligned_fetch, 0);
    rst = 1'b0;
    #1;
    check("first_req", bus.mem_request, 1);

    for (int i = 0; i < 11; i++) begin
      bus.mem_accept        = vt[i].acc[0];
      bus.mem_read_valid    = vt[i].rv[0];
      bus.mem_read_data     = word(vt[i].rd);
      bus.instruction_ready = vt[i].rdy[0];
      bus.redirect          = vt[i].redir[0];
      bus.redirect_target   = vt[i].tgt;
      @(negedge clk);
      check($sformatf("t%0d_req", i), bus.mem_request, vt[i].e_req);
      check($sformatf("t%0d_addr", i), bus.mem_address, vt[i].e_addr);
      check($sformatf("t%0d_valid", i), bus.instruction_valid, vt[i].e_iv);
      check($sformatf("t%0d_pc", i), bus.instruction_pc, vt[i].e_ipc);
      check($sformatf("t%0d_word", i), bus.instruction, vt[i].e_iv[0] ? word(vt[i].e_ipc) : 32'h0);
      check($sformatf("t%0d_mis", i), bus.misaligned_fetch, 0);
      @(posedge clk);
      #1;
    end

    // Streaming with an always-ready decoder, then a 10-cycle decoder stall.
    acc_pct = 0; rst = 1'b1; tick(); tick(); rst = 1'b0;
    acc_pct = 100; rdy_pct = 100; p0 = n_pop;
    repeat (12) tick();
    check("stream_min_rate", (n_pop - p0) >= 5, 1);
    rdy_pct = 0;
    repeat (10) tick();
    check("stall_req_low", bus.mem_request, 0);
    check("stall_valid", bus.instruction_valid, 1);
    rdy_pct = 100; p0 = n_pop;
    repeat (10) tick();
    check("after_stall_pops", (n_pop - p0) >= 3, 1);

    // Redirect coinciding with a response and an accepted request.
    acc_pct = 0;
    for (int k = 0; k < 20 && pend_addr.size() > 0; k++) tick();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    acc_pct = 100; rdy_pct = 100;
    tick();
    redirect_once(32'h100);
    check("redir_coincide", last_rv && last_acc, 1);
    check("drain_req_low", bus.mem_request, 0);
    p0 = n_pop;
    repeat (10) tick();
    check("redir_pops", (n_pop - p0) >= 2, 1);

    // Misaligned target halts fetching until an aligned redirect; only reset clears the flag.
    redirect_once(32'h102);
    repeat (6) tick();
    check("mis_set", bus.misaligned_fetch, 1);
    p0 = n_pop;
    redirect_once(32'h200);
    repeat (12) tick();
    check("resume_pops", (n_pop - p0) >= 2, 1);
    check("mis_sticky", bus.misaligned_fetch, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mis_cleared", bus.misaligned_fetch, 0);

    // PC wrap past 0xFFFFFFFC.
    p0 = n_pop;
    redirect_once(32'hFFFF_FFF8);
    repeat (14) tick();
    check("wrap_pops", (n_pop - p0) >= 3, 1);

    // Random traffic with variable latency, stalls, redirects and a mid-run reset.
    acc_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 4; p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst = 1'b1;
      if (i == 1502) rst = 1'b0;
      do_redirect = ($urandom_range(0, 99) < 3);
      redirect_to = $urandom_range(0, 1023) << 2;
      if ($urandom_range(0, 99) < 15) redirect_to[1:0] = 2'($urandom_range(1, 3));
      tick();
    end
    do_redirect = 1'b0;
    check("random_pops", (n_pop - p0) >= 100, 1);
`ifdef IFU_PERF_COUNTERS_EN
    check("fetch_count", fetch_count, pop_since_rst);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
